n64_poll_sequencer: RTL and testbench
=====================================

N64_POLL_SEQUENCER -- requirements
Module: N64_poll_sequencer

Interface
REQ-001 The block SHALL have parameter US_CYCLES, default 12, giving clock cycles per 1 us.
REQ-002 The block SHALL have parameter POLL_PERIOD, default 200000, giving clock cycles between automatic polls.
REQ-003 The block SHALL have parameter TIMEOUT_US, default 64, giving the maximum time in us allowed between response falling edges.
REQ-004 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port poll_req, input, 1 bit: request an immediate poll; honoured only in IDLE.
REQ-007 The block SHALL have port line_in, input, 1 bit: raw controller data line, asynchronous.
REQ-008 The block SHALL have port line_oe, output, 1 bit: 1 pulls the open-drain line low, 0 releases it.
REQ-009 The block SHALL have port report, output, 32 bits: last good response; bit 31 holds the first bit received.
REQ-010 The block SHALL have port report_valid, output, 1 bit: one-cycle pulse when report updates.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse on aborted response.

Function
REQ-013 line_in SHALL pass through a 2-flop synchronizer; all decode uses the synchronized value, and a falling edge means sync=0 with previous sync=1.
REQ-014 The FSM SHALL have the states IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, DONE, ERR.
REQ-015 A free-running poll timer SHALL count down from POLL_PERIOD-1 and reload whenever a poll starts; reaching 0 while not in IDLE holds it at 0 until IDLE.
REQ-016 The transition IDLE->TX_BIT SHALL occur when poll_req=1 or the timer is 0; poll_req while busy SHALL be ignored and not queued.
REQ-017 TX_BIT SHALL send command 8'h01 MSB first.
REQ-018 A 0 bit SHALL be sent as line_oe=1 for 3*US_CYCLES then 0 for 1*US_CYCLES.
REQ-019 A 1 bit SHALL be sent as line_oe=1 for 1*US_CYCLES then 0 for 3*US_CYCLES.
REQ-020 Each bit SHALL be exactly 4*US_CYCLES.
REQ-021 TX_STOP SHALL drive line_oe=1 for 1*US_CYCLES, then release and enter RX_WAIT.
REQ-022 line_oe SHALL be 0 in every state except TX_BIT and TX_STOP.
REQ-023 RX_WAIT SHALL wait for a falling edge, enter RX_BIT, and restart the us timer.
REQ-024 In RX_WAIT, if no falling edge occurs for TIMEOUT_US*US_CYCLES cycles, the FSM SHALL go to ERR.
REQ-025 RX_BIT SHALL sample the synced line exactly 2*US_CYCLES cycles after the edge and shift that value into a 33-bit shift register (1 = high).
REQ-026 After the sample, RX_BIT SHALL return to RX_WAIT until 33 samples are taken (32 data plus stop), then go to DONE.
REQ-027 The receive bit counter SHALL be 6 bits and SHALL clear on entry to TX_BIT.
REQ-028 In DONE, for one cycle, report SHALL be set to the first 32 samples, report_valid=1 for one cycle, then the FSM SHALL return to IDLE; the stop sample SHALL be discarded.
REQ-029 In ERR, for one cycle, timeout_err=1, report SHALL be unchanged, then the FSM SHALL return to IDLE.
REQ-030 A falling edge seen during TX states (own drive) SHALL be ignored.
REQ-031 Extra falling edges after 33 samples SHALL be ignored in IDLE.

Reset
REQ-032 In any state, reset=1 SHALL force state IDLE, line_oe=0, report=0, report_valid=0, timeout_err=0, busy=0, all counters 0, synchronizer flops 1, and poll timer POLL_PERIOD-1, effective at the next rising edge.
REQ-033 Reset mid-transmit SHALL release line_oe on the edge reset is sampled.

Verification
REQ-034 US_CYCLES=4, poll_req pulse in IDLE -> line_oe shows seven 0-bits (12 low/4 high), one 1-bit (4 low/12 high), then stop of 4 low; busy=1 throughout.
REQ-035 Controller model answers 32'h8000_00FF + stop after command -> report_valid single pulse, report=32'h8000_00FF, busy falls next cycle.
REQ-036 No response after command -> timeout_err pulses exactly TIMEOUT_US*US_CYCLES cycles (plus synchronizer latency) after stop release; report keeps prior value.
REQ-037 POLL_PERIOD=1000, no poll_req -> polls start every 1000 cycles; poll_req asserted mid-transaction does not create a second poll.
REQ-038 Response truncated after 20 bits -> timeout_err pulse, report unchanged; next poll with a full response updates report normally.
REQ-039 Reset asserted during TX_BIT bit 3 -> line_oe=0 and busy=0 next edge; after deassert, the first poll restarts at bit 7 of command.

Source files
------------

// File: rtl/n64_poll_sequencer.sv
// N64 controller poll sequencer.
// Periodically (or on request) sends the status/poll command 8'h01 on the
// open-drain controller line, then decodes the 32-bit button report plus stop
// bit that the controller returns. Bad or missing responses abort with a
// one-cycle timeout_err pulse and leave the last good report untouched.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line released, waiting for poll_req or poll timer expiry
// TX_BIT  | shifting out command bits MSB first, 4 us per bit
// TX_STOP | 1 us low console stop bit
// RX_WAIT | line released, waiting for the next response falling edge
// RX_BIT  | 2 us after a falling edge, sample the line into the shifter
// DONE    | full response captured, report/report_valid presented
// ERR     | response timed out, timeout_err presented

module n64_poll_sequencer #(
  parameter int US_CYCLES   = 12,
  parameter int POLL_PERIOD = 200000,
  parameter int TIMEOUT_US  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        line_in,
  output logic        line_oe,
  output logic [31:0] report,
  output logic        report_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TX_BIT  = 3'd1;
  localparam logic [2:0] TX_STOP = 3'd2;
  localparam logic [2:0] RX_WAIT = 3'd3;
  localparam logic [2:0] RX_BIT  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam logic [7:0] CMD = 8'h01;

  localparam int BIT_CYC = 4 * US_CYCLES;
  localparam int TO_CYC  = TIMEOUT_US * US_CYCLES;
  localparam int TMR_W   = $clog2(BIT_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam int POLL_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [TMR_W-1:0]  BIT_LOAD  = TMR_W'(BIT_CYC - 1);
  localparam logic [TMR_W-1:0]  US_LOAD   = TMR_W'(US_CYCLES - 1);
  localparam logic [TMR_W-1:0]  HALF_LOAD = TMR_W'(2 * US_CYCLES - 1);
  localparam logic [TMR_W-1:0]  ONE_TH    = TMR_W'(3 * US_CYCLES);
  localparam logic [TMR_W-1:0]  ZERO_TH   = TMR_W'(US_CYCLES);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TO_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_PERIOD - 1);

  logic [2:0]        state;
  logic [TMR_W-1:0]  tmr;
  logic [TO_W-1:0]   to_tmr;
  logic [POLL_W-1:0] poll_cnt;
  logic [2:0]        tx_idx;
  logic [5:0]        rx_cnt;
  logic [32:0]       rx_shreg;
  logic [31:0]       report_q;
  logic              sync_meta;
  logic              sync_q;
  logic              sync_prev;
  logic              fall;
  logic              poll_start;

  assign fall       = sync_prev & ~sync_q;
  assign poll_start = (state == IDLE) && (poll_req || (poll_cnt == '0));

  // Bring the asynchronous controller line into the clock domain; idle-high reset
  // value keeps a falling edge from appearing right after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= line_in;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  // Free-running poll interval timer; parks at zero while a transaction runs so
  // an overdue poll fires as soon as the sequencer returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      poll_cnt <= POLL_LOAD;
    end else if (poll_start) begin
      poll_cnt <= POLL_LOAD;
    end else if (poll_cnt != '0) begin
      poll_cnt <= poll_cnt - 1'b1;
    end
  end

  // Transaction sequencer: command transmit, response capture and completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      to_tmr   <= '0;
      tx_idx   <= '0;
      rx_cnt   <= '0;
      rx_shreg <= '0;
      report_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (poll_start) begin
            state    <= TX_BIT;
            tx_idx   <= 3'd7;
            tmr      <= BIT_LOAD;
            rx_cnt   <= '0;
            rx_shreg <= '0;
          end
        end

        TX_BIT: begin
          if (tmr == '0) begin
            if (tx_idx == '0) begin
              state <= TX_STOP;
              tmr   <= US_LOAD;
            end else begin
              tx_idx <= tx_idx - 3'd1;
              tmr    <= BIT_LOAD;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        TX_STOP: begin
          if (tmr == '0) begin
            state  <= RX_WAIT;
            to_tmr <= TO_LOAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        RX_WAIT: begin
          if (fall) begin
            state  <= RX_BIT;
            tmr    <= HALF_LOAD;
            to_tmr <= TO_LOAD;
          end else if (to_tmr == '0) begin
            state <= ERR;
          end else begin
            to_tmr <= to_tmr - 1'b1;
          end
        end

        RX_BIT: begin
          // The edge-to-edge timeout keeps running while the bit is being sampled.
          if (to_tmr != '0) begin
            to_tmr <= to_tmr - 1'b1;
          end
          if (tmr == '0) begin
            rx_shreg <= {rx_shreg[31:0], sync_q};
            rx_cnt   <= rx_cnt + 6'd1;
            state    <= (rx_cnt == 6'd32) ? DONE : RX_WAIT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        DONE: begin
          report_q <= rx_shreg[32:1];
          state    <= IDLE;
        end

        ERR: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Open-drain drive: 0 bits are 3 us low / 1 us high, 1 bits 1 us low / 3 us
  // high, counted on the per-bit down-counter; the stop bit is held low.
  always_comb begin
    line_oe = 1'b0;
    case (state)
      TX_BIT:  line_oe = CMD[tx_idx] ? (tmr >= ONE_TH) : (tmr >= ZERO_TH);
      TX_STOP: line_oe = 1'b1;
      default: line_oe = 1'b0;
    endcase
  end

  // Status outputs; the new report is shown already during DONE so it lines up
  // with report_valid, the stop sample in rx_shreg[0] is dropped.
  always_comb begin
    busy         = (state != IDLE);
    report_valid = (state == DONE);
    timeout_err  = (state == ERR);
    report       = (state == DONE) ? rx_shreg[32:1] : report_q;
  end

endmodule

// File: tb/tb_n64_poll_sequencer.sv
// Directed bench for n64_poll_sequencer with a simple open-drain controller model.
module tb_n64_poll_sequencer;

  localparam int US = 4;
  localparam int TO = 64;
  localparam int PP = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        poll_req;
  logic        ctrl_low;
  logic        line_in;
  logic        line_oe;
  logic [31:0] report;
  logic        report_valid;
  logic        busy;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign line_in = ~(line_oe | ctrl_low);

  n64_poll_sequencer #(
    .US_CYCLES  (US),
    .POLL_PERIOD(PP),
    .TIMEOUT_US (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .poll_req    (poll_req),
    .line_in     (line_in),
    .line_oe     (line_oe),
    .report      (report),
    .report_valid(report_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line_oe for cycle k of the command: seven 0-bits, one 1-bit, stop.
  function automatic logic exp_oe(input int k);
    if (k >= 128) return 1'b1;
    if (k / 16 == 7) return (k % 16) < 4;
    return (k % 16) < 12;
  endfunction

  // Called at the first negedge where busy is high.
  task automatic check_tx(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clock);
      chk($sformatf("tx_oe[%0d]", k), line_oe, exp_oe(k));
      chk($sformatf("tx_busy[%0d]", k), busy, 1);
    end
  endtask

  task automatic drive_bit(input logic b);
    ctrl_low = 1'b1;
    repeat (b ? US : 3 * US) @(negedge clock);
    ctrl_low = 1'b0;
    repeat (b ? 3 * US : US) @(negedge clock);
  endtask

  task automatic wait_busy(output int t);
    int n;
    n = 0;
    while (!busy && n < 1200) begin
      @(negedge clock);
      n++;
    end
    chk("poll_start_seen", busy, 1);
    t = cyc;
  endtask

  task automatic respond_full(input logic [31:0] data);
    int n;
    repeat (8) @(negedge clock);
    for (int i = 31; i >= 0; i--) drive_bit(data[i]);
    ctrl_low = 1'b1;
    repeat (US) @(negedge clock);
    ctrl_low = 1'b0;
    n = US;
    while (!report_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("done_latency", n, 11);
    chk("report_valid", report_valid, 1);
    chk("report", report, data);
    chk("busy_in_done", busy, 1);
    @(negedge clock);
    chk("report_valid_pulse", report_valid, 0);
    chk("busy_after_done", busy, 0);
    chk("report_hold", report, data);
  endtask

  initial begin
    int t1, t2, t3, t4, n;
    logic rv_seen;
    logic [19:0] trunc;

    reset    = 1'b1;
    poll_req = 1'b0;
    ctrl_low = 1'b0;
    trunc    = 20'hA5C3F;
    repeat (3) @(negedge clock);
    chk("rst_line_oe", line_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_report", report, 0);
    chk("rst_report_valid", report_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_busy", busy, 0);

    // Requested poll, full response
    poll_req = 1'b1;
    @(negedge clock);
    poll_req = 1'b0;
    t1 = cyc;
    check_tx(132);
    respond_full(32'h8000_00FF);

    // Automatic poll, no response, poll_req during the transaction
    wait_busy(t2);
    chk("poll_interval_1", t2 - t1, PP);
    check_tx(132);
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clock);
      n++;
      poll_req = (n == 1);
    end
    poll_req = 1'b0;
    chk("timeout_latency", n, 257);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_report_kept", report, 32'h8000_00FF);
    chk("timeout_no_valid", report_valid, 0);
    @(negedge clock);
    chk("timeout_err_pulse", timeout_err, 0);
    chk("busy_after_err", busy, 0);

    // Next automatic poll not advanced by the ignored request; truncated response
    wait_busy(t3);
    chk("poll_interval_2", t3 - t2, PP);
    check_tx(132);
    repeat (8) @(negedge clock);
    for (int i = 19; i >= 0; i--) drive_bit(trunc[i]);
    n = 0;
    rv_seen = 1'b0;
    while (!timeout_err && n < 400) begin
      @(negedge clock);
      n++;
      if (report_valid) rv_seen = 1'b1;
    end
    chk("trunc_timeout_latency", n, 243);
    chk("trunc_no_valid", rv_seen, 0);
    chk("trunc_report_kept", report, 32'h8000_00FF);
    @(negedge clock);

    // Following poll with a full response updates normally
    wait_busy(t4);
    chk("poll_interval_3", t4 - t3, PP);
    check_tx(132);
    respond_full(32'h1234_ABCD);

    // Reset in the middle of command bit 3
    @(negedge clock);
    poll_req = 1'b1;
    @(negedge clock);
    poll_req = 1'b0;
    check_tx(69);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_line_oe", line_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_report", report, 0);
    chk("midrst_report_valid", report_valid, 0);
    chk("midrst_timeout_err", timeout_err, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    poll_req = 1'b1;
    @(negedge clock);
    poll_req = 1'b0;
    check_tx(132);
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("post_rst_timeout_latency", n, 257);
    chk("post_rst_report", report, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
